demux1hot_stream_with_default: RTL and testbench
================================================

# demux1hot_stream_with_default

Registered one-hot stream demultiplexer with default sink. It routes a single valid/ready input stream to one of OUTPUTS destination ports, chosen by a one-hot select, and sends it to a dedicated default port when the select is all-zero or not one-hot. It sits downstream of a producer that owns the select and is the distributing counterpart of the one-hot merge muxes used on the gathering side. The output stage is a one-entry register, so it sustains one transfer per cycle.

## Interface
- OUTPUTS, 2: number of selectable destination ports (≥1).
- WIDTH, 1: data width in bits.
- clk  in  1: the single clock; all state is rising-edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: input beat valid.
- in_ready  out  1: input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH: input payload.
- in_sel  in  OUTPUTS: one-hot destination; sampled with the beat.
- out_valid  out  OUTPUTS: per-port valid; port i occupies bit i.
- out_ready  in  OUTPUTS: per-port ready.
- out_data  out  WIDTH*OUTPUTS: packed lanes; lane i is [WIDTH*i +: WIDTH].
- dflt_valid  out  1: default-port valid.
- dflt_ready  in  1: default-port ready.
- dflt_data  out  WIDTH: default-port payload.
- err  out  1: sticky flag, set by an accepted beat whose in_sel has two or more bits set.
- err_clr  in  1: synchronous clear of err.

## Operation
- State: full bit, data register, dest register (OUTPUTS+1 bits, one-hot; MSB = default).
- Destination decode on accept: popcount(in_sel)==1 → dest = {1'b0, in_sel}; popcount 0 → default; popcount ≥2 → default, and err is set.
- Selected-port ready: drain = full && |(dest & {dflt_ready, out_ready}).
- in_ready = !full || drain. This is combinational from out_ready/dflt_ready and does not depend on in_valid.
- On accept: load data/dest and set full. On drain without accept: clear full. On drain and accept in the same cycle: reload and keep full=1 (back-to-back).
- out_valid[i] = full && dest[i]; dflt_valid = full && dest[OUTPUTS]. At most one valid is high in any cycle.
- Lane data: the selected lane (or dflt_data) carries the data register. All non-selected lanes and dflt_data are driven 0.
- err_clr with a simultaneous error-setting accept: set wins (err stays 1).
- Held beat: dest and data are stable while valid && !ready. The held beat does not change when in_sel or in_data change.

## Timing
- Latency: accept at edge N → valid visible in the cycle after edge N.
- Throughput: 1 beat/cycle when the selected port is continuously ready.
- Reset (asynchronous assert, synchronous-release by the system): full=0, dest=0, data=0, err=0. As a result every out_valid=0, dflt_valid=0, all out_data/dflt_data=0, and in_ready=1.
- Reset mid-transfer: the held beat is dropped and no valid is produced after release.
- A non-selected port's out_ready has no effect, including while another port stalls. Head-of-line blocking is intended.

## Structure
- Shared package hbb_stream_pkg: popcount/one-hot-check function `is_onehot`, and a constant `DFLT_IDX` expressed as OUTPUTS.
- One sub-module, onehot_classify (combinational): in_sel → {zero, onehot, multi}. The decode is reused by the arbiter blocks.
- The top module holds the output register and the handshake logic.

## Test plan
- Reset: assert rst_n=0 mid-beat (full=1, dest=port 1) → all valids 0, err=0, in_ready=1 immediately; no beat appears after release.
- Routing, OUTPUTS=4, WIDTH=8: send 0x11..0x44 with sel 0001,0010,0100,1000, all ready → each lane shows its value 1 cycle after accept, other lanes 0, 4 beats in 4 cycles.
- Default path: sel=0000, data 0xA5 → dflt_valid=1, dflt_data=0xA5, err=0. Then sel=0110, data 0x5A → default port, err=1; err_clr pulse → err=0.
- Back-pressure: port 2 out_ready=0 for 5 cycles with 3 beats offered → in_ready=0 while full, held data is stable, other readies are ignored; ready=1 → the beats drain one per cycle in order.
- Back-to-back drain+accept: selected ready=1 and in_valid=1 every cycle for 16 beats with alternating dests → no bubbles, and order and data are preserved.
- Set/clear collision: err_clr=1 in the same cycle as a multi-hot accept → err=1 next cycle.

Source files
------------

// File: rtl/hbb_stream_pkg.sv
// rtl/hbb_stream_pkg.sv - shared stream helpers: popcount, one-hot check, default-port index
package hbb_stream_pkg;

  // Widest select vector the helper functions accept; callers zero-extend into it.
  localparam int MAX_PORTS = 32;

  function automatic int unsigned popcount(input logic [MAX_PORTS-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic is_onehot(input logic [MAX_PORTS-1:0] v);
    return popcount(v) == 32'd1;
  endfunction

  // The default sink sits just above the selectable ports in the dest vector.
  function automatic int dflt_idx(input int outputs);
    return outputs;
  endfunction

endpackage

// File: rtl/onehot_classify.sv
// rtl/onehot_classify.sv - classifies a select vector as zero, one-hot or multi-hot
// Ports:
//   sel         in  N : select vector
//   sel_zero    out 1 : no bit set
//   sel_onehot  out 1 : exactly one bit set
//   sel_multi   out 1 : two or more bits set
module onehot_classify
  import hbb_stream_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] sel,
  output logic         sel_zero,
  output logic         sel_onehot,
  output logic         sel_multi
);

  logic [MAX_PORTS-1:0] sel_ext;

  always_comb begin
    sel_ext        = '0;
    sel_ext[N-1:0] = sel;
  end

  always_comb begin
    sel_zero   = (sel == '0);
    sel_onehot = is_onehot(sel_ext);
    sel_multi  = !sel_zero && !sel_onehot;
  end

endmodule

// File: rtl/demux1hot_stream_with_default.sv
// rtl/demux1hot_stream_with_default.sv - registered one-hot stream demux with default sink
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/ready/data   : input stream; in_sel is the one-hot destination
//   out_valid/ready/data  : OUTPUTS destination ports, lane i = out_data[WIDTH*i +: WIDTH]
//   dflt_valid/ready/data : default sink for zero or multi-hot selects
//   err, err_clr          : sticky multi-hot flag and its synchronous clear
module demux1hot_stream_with_default
  import hbb_stream_pkg::*;
#(
  parameter int OUTPUTS = 2,
  parameter int WIDTH   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [OUTPUTS-1:0]         in_sel,
  output logic [OUTPUTS-1:0]         out_valid,
  input  logic [OUTPUTS-1:0]         out_ready,
  output logic [WIDTH*OUTPUTS-1:0]   out_data,
  output logic                       dflt_valid,
  input  logic                       dflt_ready,
  output logic [WIDTH-1:0]           dflt_data,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int DFLT_IDX = dflt_idx(OUTPUTS);

  logic               full_q;
  logic [OUTPUTS:0]   dest_q;
  logic [OUTPUTS:0]   dest_d;
  logic [WIDTH-1:0]   data_q;
  logic               err_q;
  logic               sel_zero;
  logic               sel_onehot;
  logic               sel_multi;
  logic               drain;
  logic               accept;

  onehot_classify #(
    .N (OUTPUTS)
  ) u_classify (
    .sel        (in_sel),
    .sel_zero   (sel_zero),
    .sel_onehot (sel_onehot),
    .sel_multi  (sel_multi)
  );

  always_comb begin
    dest_d                = '0;
    dest_d[OUTPUTS-1:0]   = sel_onehot ? in_sel : '0;
    dest_d[DFLT_IDX]      = sel_zero | sel_multi;
  end

  // Only the held beat's own destination can drain it; other readies are ignored.
  assign drain    = full_q && |(dest_q & {dflt_ready, out_ready});
  assign in_ready = !full_q || drain;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      dest_q <= dest_d;
      data_q <= in_data;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  // Setting has priority so a multi-hot beat is never lost to a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && sel_multi) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      out_valid[i]               = full_q && dest_q[i];
      out_data[WIDTH*i +: WIDTH] = {WIDTH{full_q && dest_q[i]}} & data_q;
    end
    dflt_valid = full_q && dest_q[DFLT_IDX];
    dflt_data  = {WIDTH{full_q && dest_q[DFLT_IDX]}} & data_q;
  end

endmodule

// File: tb/tb_demux1hot_stream_with_default.sv
// tb/tb_demux1hot_stream_with_default.sv - scoreboard bench for the one-hot stream demux
module tb_demux1hot_stream_with_default;

  localparam int OUTPUTS = 4;
  localparam int WIDTH   = 8;

  typedef struct {
    int         port;
    logic [7:0] data;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic [OUTPUTS-1:0]       in_sel;
  logic [OUTPUTS-1:0]       out_valid;
  logic [OUTPUTS-1:0]       out_ready;
  logic [WIDTH*OUTPUTS-1:0] out_data;
  logic                     dflt_valid;
  logic                     dflt_ready;
  logic [WIDTH-1:0]         dflt_data;
  logic                     err;
  logic                     err_clr;

  beat_t q[$];
  logic  exp_err;
  logic  last_accept;
  int    n_checks;
  int    n_fail;

  demux1hot_stream_with_default #(
    .OUTPUTS (OUTPUTS),
    .WIDTH   (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .dflt_valid (dflt_valid),
    .dflt_ready (dflt_ready),
    .dflt_data  (dflt_data),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, compare outputs against the scoreboard head,
  // then advance the model as the coming rising edge will.
  task automatic cycle(input logic v, input logic [3:0] sel, input logic [7:0] d,
                       input logic [3:0] ordy, input logic drdy, input logic eclr);
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
    logic        exp_dv;
    logic [7:0]  exp_dd;
    logic        sel_rdy;
    logic        exp_ir;
    beat_t       b;
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out_ready  = ordy;
    dflt_ready = drdy;
    err_clr    = eclr;
    #1;
    exp_ov  = '0;
    exp_od  = '0;
    exp_dv  = 1'b0;
    exp_dd  = '0;
    sel_rdy = 1'b0;
    if (q.size() != 0) begin
      if (q[0].port == OUTPUTS) begin
        exp_dv  = 1'b1;
        exp_dd  = q[0].data;
        sel_rdy = drdy;
      end else begin
        exp_ov[q[0].port]          = 1'b1;
        exp_od[q[0].port*8 +: 8]   = q[0].data;
        sel_rdy                    = ordy[q[0].port];
      end
    end
    exp_ir = (q.size() == 0) || sel_rdy;
    chk("out_valid",  32'(out_valid),  32'(exp_ov));
    chk("out_data",   out_data,        exp_od);
    chk("dflt_valid", 32'(dflt_valid), 32'(exp_dv));
    chk("dflt_data",  32'(dflt_data),  32'(exp_dd));
    chk("in_ready",   32'(in_ready),   32'(exp_ir));
    chk("err",        32'(err),        32'(exp_err));
    if (q.size() != 0 && sel_rdy) void'(q.pop_front());
    last_accept = v && exp_ir;
    if (last_accept) begin
      b.port = OUTPUTS;
      b.data = d;
      if ($countones(sel) == 1) begin
        for (int i = 0; i < OUTPUTS; i++) if (sel[i]) b.port = i;
      end
      q.push_back(b);
      if ($countones(sel) >= 2) exp_err = 1'b1;
      else if (eclr) exp_err = 1'b0;
    end else if (eclr) begin
      exp_err = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    n_checks   = 0;
    n_fail     = 0;
    exp_err    = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = '0;
    in_data    = '0;
    out_ready  = '0;
    dflt_ready = 1'b0;
    err_clr    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then one beat to each port back to back.
    cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'(1 << i), 8'(8'h11 * (i + 1)), 4'hF, 1'b1, 1'b0);
      chk("route_accept", 32'(last_accept), 32'd1);
    end
    repeat (2) cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b0);

    // Zero select, then multi-hot select, then clear.
    cycle(1'b1, 4'b0000, 8'hA5, 4'hF, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b0);
    cycle(1'b1, 4'b0110, 8'h5A, 4'hF, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b1);
    cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b0);

    // Port 2 stalled for 5 cycles while other readies toggle.
    k = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 4'b0100, 8'(8'hC1 + k), (c % 2 == 0) ? 4'b1011 : 4'b0000, c[0], 1'b0);
      if (last_accept) k++;
    end
    chk("stall_accepts", 32'(k), 32'd1);
    for (int c = 0; c < 10 && (k < 3 || q.size() != 0); c++) begin
      cycle(k < 3, 4'b0100, 8'(8'hC1 + k), 4'hF, 1'b1, 1'b0);
      if (last_accept) k++;
    end
    chk("stall_drained", 32'(q.size()), 32'd0);

    // 16 beats, drain and accept every cycle, mixed destinations.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, (i % 5 == 4) ? 4'b0000 : 4'(1 << (i % 4)), 8'($urandom_range(0, 255)),
            4'hF, 1'b1, 1'b0);
      chk("b2b_accept", 32'(last_accept), 32'd1);
    end
    repeat (2) cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b0);

    // Clear coinciding with a multi-hot accept: set wins.
    cycle(1'b1, 4'b1001, 8'h77, 4'hF, 1'b1, 1'b1);
    cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b0);

    // Reset while a beat to port 1 is held.
    cycle(1'b1, 4'b0010, 8'h99, 4'b0000, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   out_data,        32'd0);
    chk("rst_dflt_valid", 32'(dflt_valid), 32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_err",        32'(err),        32'd0);
    q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 4'b0000, 8'h00, 4'hF, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
